// File: rtl/dec_pkg.sv
// dec_pkg: shared state encoding and decode helper for the dec_stream block.
`default_nettype none

package dec_pkg;

    localparam int C_MAX_IN_W  = 8;
    localparam int C_MAX_OUT_W = 2 ** C_MAX_IN_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Widest supported decode; callers keep the low 2**IN_W bits.
    function automatic logic [C_MAX_OUT_W-1:0] onehot_of(
        input logic [C_MAX_IN_W-1:0] code,
        input logic                  en
    );
        logic [C_MAX_OUT_W-1:0] one;
        one       = {{(C_MAX_OUT_W-1){1'b0}}, 1'b1};
        onehot_of = en ? (one << code) : '0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dec_skid_buf.sv
// dec_skid_buf: 2-entry valid/ready buffer; in_ready_o depends only on registered state.
`default_nettype none

module dec_skid_buf
    import dec_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] head_q,  head_d;
    logic [DATA_W-1:0] skid_q,  skid_d;
    logic              w_in_fire;
    logic              w_out_fire;

    assign in_ready_o  = (state_q != ST_FULL);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = head_q;
    assign w_in_fire   = in_valid_i && in_ready_o;
    assign w_out_fire  = out_valid_o && out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    head_d  = in_data_i;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    head_d = in_data_i;
                end else if (w_in_fire) begin
                    skid_d  = in_data_i;
                    state_d = ST_FULL;
                end else if (w_out_fire) begin
                    // Clear head so the output word reads zero while empty.
                    head_d  = '0;
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_fire) begin
                    head_d  = skid_q;
                    skid_d  = '0;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                head_d  = '0;
                skid_d  = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dec_stream.sv
// dec_stream: streaming binary-to-one-hot decoder with skid buffering and a transfer counter.
`default_nettype none

module dec_stream
    import dec_pkg::*;
#(
    parameter int IN_W  = 2,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_code,
    input  logic                  in_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [(2**IN_W)-1:0]  out_onehot,
    output logic [CNT_W-1:0]      dec_count
);

    localparam int OUT_W = 2 ** IN_W;

    logic [C_MAX_IN_W-1:0]  w_code_ext;
    logic [C_MAX_OUT_W-1:0] w_full;
    logic [OUT_W-1:0]       w_word;
    logic [CNT_W-1:0]       cnt_q;

    always_comb begin
        w_code_ext            = '0;
        w_code_ext[IN_W-1:0]  = in_code;
    end

    assign w_full = onehot_of(w_code_ext, in_en);
    assign w_word = w_full[OUT_W-1:0];

    generate
        if (OUT_W < C_MAX_OUT_W) begin : g_trim
            logic w_unused_hi;
            assign w_unused_hi = |w_full[C_MAX_OUT_W-1:OUT_W];
        end
    endgenerate

    dec_skid_buf #(
        .DATA_W (OUT_W)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (w_word),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (out_valid && out_ready) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign dec_count = cnt_q;

endmodule

`default_nettype wire

// File: doc/dec_stream.md
Name: dec_stream

Overview:
- Streaming binary-to-one-hot decoder: accepts IN_W-bit codes on a valid/ready input and emits 2^IN_W-bit one-hot words on a valid/ready output.
- It is the receive-side counterpart to the team's 4-bit case encoder. It sits between an encoder-driven code bus and downstream one-hot select logic.
- A 2-entry skid buffer decouples backpressure, so in_ready depends only on registered state.

Parameters:
- IN_W, 2, width of the input code; output width OUT_W = 2**IN_W (derived, not overridable).
- CNT_W, 8, width of the decoded-word counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_code/in_en are valid
- in_ready  output  1  block can accept a word this cycle
- in_code  input  IN_W  binary code to decode
- in_en  input  1  decode enable; 0 produces an all-zero output word
- out_valid  output  1  out_onehot holds a valid word
- out_ready  input  1  downstream accepts the word
- out_onehot  output  OUT_W  decoded word; bit in_code set when in_en=1
- dec_count  output  CNT_W  number of completed output transfers, modulo 2**CNT_W

Behaviour:
- Transfers occur only when valid and ready are both 1 on a clk edge. Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Decode is combinational on the input side. Stored entries hold the decoded OUT_W word, not the code.
- Storage is two registers: head (drives out_onehot) and skid.
- FSM states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: head valid, out_valid=1, in_ready=1.
  - FULL: head and skid valid, out_valid=1, in_ready=0.
- in_ready = (state != FULL). It is a pure function of the state register, with no combinational path from out_ready.
- EMPTY:
  - input transfer: word loads into head, go to ONE.
  - otherwise: stay.
- ONE:
  - input only: word loads into skid, go to FULL.
  - output only: go to EMPTY.
  - input and output in the same cycle: new word loads into head, stay ONE.
  - neither: stay.
- FULL:
  - output transfer: skid moves to head, go to ONE.
  - otherwise: stay. in_valid is ignored.
- Latency: an input accepted in EMPTY appears on out_onehot with out_valid=1 on the next cycle. Throughput is 1 word/cycle when out_ready is held high.
- Ordering is strict FIFO; no word is dropped or duplicated.
- While out_valid=1 and out_ready=0, out_onehot is held stable.
- in_en=0 yields an all-zero word. It still counts as a normal transfer and increments dec_count.
- dec_count increments by 1 on each output transfer and wraps from 2**CNT_W-1 to 0.
- Reset: rst_n low asynchronously forces state=EMPTY, head=skid=0, dec_count=0. Resulting outputs: out_valid=0, out_onehot=0, in_ready=1, dec_count=0.
- Reset mid-operation discards buffered words; no output transfer is reported for them. Normal operation resumes on the first clk edge after rst_n deasserts.
- out_onehot is 0 whenever state=EMPTY.

Decomposition:
- Shared package dec_pkg:
  - state enum (ST_EMPTY, ST_ONE, ST_FULL), 2-bit encoding.
  - function onehot_of(code, en) returning the OUT_W word.
- One natural sub-module: dec_skid_buf, the 2-entry valid/ready buffer, parameterised on data width.
- dec_stream instantiates dec_skid_buf with width OUT_W and adds the decode function and the counter.

Test Plan (IN_W=2, CNT_W=8):
- Reset, then in_code=2'b10, in_en=1, in_valid=1 for one cycle, out_ready=1 -> next cycle out_valid=1, out_onehot=4'b0100; dec_count=1 after the transfer.
- out_ready=0; push codes 0, 3, 1 back-to-back -> codes 0 and 3 accepted; in_ready=0 after the 2nd acceptance; code 1 stalls. Raise out_ready -> outputs 4'b0001, 4'b1000, 4'b0010 in order, 3 transfers, dec_count=3.
- in_en=0 with in_code=2'b11 -> out_onehot=4'b0000 with out_valid=1; dec_count still increments.
- Continuous in_valid=out_ready=1 with codes 0,1,2,3 repeating for 300 cycles -> one output per cycle after 1-cycle latency; dec_count wraps 255->0 and reads 300 mod 256 = 44 at the end.
- FULL state, assert rst_n=0 asynchronously mid-cycle -> out_valid, out_onehot and dec_count go to 0 immediately and in_ready=1; no buffered word appears after release.
- State ONE with simultaneous input transfer (code 1) and output transfer -> state stays ONE; next out_onehot=4'b0010; no word lost.
